// File: rtl/pulse_detector_mc_if.sv
// Signal bundle for pulse_detector_mc: raw inputs, shared config and per-channel status.
// The master side drives stimulus and configuration; the slave side is the detector.
interface pulse_detector_mc_if #(
  parameter int NUM_CH  = 4,
  parameter int DELAY_W = 8,
  parameter int WIDTH_W = 8
);
  logic [NUM_CH-1:0]  sig_in;
  logic [NUM_CH-1:0]  ch_en;
  logic [1:0]         mode;
  logic [DELAY_W-1:0] delay;
  logic [WIDTH_W-1:0] min_width;
  logic [NUM_CH-1:0]  clr_ovr;
  logic [NUM_CH-1:0]  sig_out;
  logic [NUM_CH-1:0]  busy;
  logic [NUM_CH-1:0]  ovr;

  modport master (
    output sig_in, ch_en, mode, delay, min_width, clr_ovr,
    input  sig_out, busy, ovr
  );

  modport slave (
    input  sig_in, ch_en, mode, delay, min_width, clr_ovr,
    output sig_out, busy, ovr
  );
endinterface

// File: rtl/pulse_detector_mc.sv
// Multi-channel edge/pulse detector with per-channel delayed one-cycle strobe and overrun flag.
// Optional PULSE_DETECTOR_SYNC_EN inserts a 2-flop synchroniser ahead of the edge sampler.
module pulse_detector_mc #(
  parameter int NUM_CH  = 4,
  parameter int DELAY_W = 8,
  parameter int WIDTH_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  pulse_detector_mc_if.slave bus
);
  typedef enum logic {IDLE, WAIT} state_t;

  logic [NUM_CH-1:0] samp;
  logic [NUM_CH-1:0] s0;
  logic [NUM_CH-1:0] s1;

`ifdef PULSE_DETECTOR_SYNC_EN
  logic [NUM_CH-1:0] sync0;
  logic [NUM_CH-1:0] sync1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= bus.sig_in;
      sync1 <= sync0;
    end
  end

  assign samp = sync1;
`else
  assign samp = bus.sig_in;
`endif

  // NOTE: sequential state is assigned with <= only, so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0 <= '0;
      s1 <= '0;
    end else begin
      s0 <= samp;
      s1 <= s0;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t             state;
    logic [DELAY_W-1:0] cnt;
    logic [WIDTH_W-1:0] high_cnt;
    logic               strobe;
    logic               ovr_q;
    logic               rise;
    logic               fall;
    logic               evt;

    assign rise = s0[i] & ~s1[i];
    assign fall = ~s0[i] & s1[i];

    // NOTE: evt gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
      evt = 1'b0;
      case (bus.mode)
        2'b00:   evt = rise;
        2'b01:   evt = fall;
        2'b10:   evt = rise | fall;
        default: evt = fall && (high_cnt >= bus.min_width);
      endcase
      evt = evt & bus.ch_en[i];
    end

    // High time seen at the falling edge equals the pulse length, capped at all-ones.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        high_cnt <= '0;
      end else if (!s0[i]) begin
        high_cnt <= '0;
      end else if (high_cnt != '1) begin
        high_cnt <= high_cnt + WIDTH_W'(1);
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state  <= IDLE;
        cnt    <= '0;
        strobe <= 1'b0;
        ovr_q  <= 1'b0;
      end else begin
        strobe <= 1'b0;
        if (bus.clr_ovr[i]) ovr_q <= 1'b0;
        case (state)
          IDLE: begin
            if (evt) begin
              if (bus.delay == '0) begin
                strobe <= 1'b1;
              end else begin
                cnt   <= bus.delay;
                state <= WAIT;
              end
            end
          end
          WAIT: begin
            if (cnt == DELAY_W'(1)) begin
              // Final wait cycle: fire the pending strobe and accept a new event as if idle.
              strobe <= 1'b1;
              state  <= IDLE;
              if (evt && bus.delay != '0) begin
                cnt   <= bus.delay;
                state <= WAIT;
              end
            end else begin
              cnt <= cnt - DELAY_W'(1);
              if (evt) ovr_q <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign bus.sig_out[i] = strobe;
    assign bus.busy[i]    = (state == WAIT);
    assign bus.ovr[i]     = ovr_q;
  end
endmodule

// File: tb/tb_pulse_detector_mc.sv
// Scoreboard bench for pulse_detector_mc: stimulus queues expected strobe cycles,
// a negedge monitor matches every sig_out bit against the queue.
module tb_pulse_detector_mc;
  localparam int NUM_CH  = 4;
  localparam int DELAY_W = 8;
  localparam int WIDTH_W = 8;
`ifdef PULSE_DETECTOR_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  typedef struct {
    int ch;
    int at;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  pulse_detector_mc_if #(.NUM_CH(NUM_CH), .DELAY_W(DELAY_W), .WIDTH_W(WIDTH_W)) bus ();

  pulse_detector_mc #(.NUM_CH(NUM_CH), .DELAY_W(DELAY_W), .WIDTH_W(WIDTH_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called in the same negedge slot that changes sig_in for the qualifying edge.
  task automatic expect_strobe(input int c, input int d);
    exp_t e;
    e.ch = c;
    e.at = cyc + 2 + d + SL;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    int hit;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.sig_out[c]) begin
        hit = -1;
        for (int k = 0; k < exp_q.size(); k++)
          if (exp_q[k].ch == c && exp_q[k].at == cyc) hit = k;
        checks++;
        if (hit >= 0) begin
          exp_q.delete(hit);
        end else begin
          errors++;
          $display("FAIL strobe_ch%0d: got sig_out=1 expected 0 at cycle %0d", c, cyc);
        end
      end
    end
    for (int k = exp_q.size() - 1; k >= 0; k--) begin
      if (exp_q[k].at < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_strobe_ch%0d: got sig_out=0 expected 1 at cycle %0d",
                 exp_q[k].ch, exp_q[k].at);
        exp_q.delete(k);
      end
    end
  end

  initial begin
    bus.sig_in    = '0;
    bus.ch_en     = '1;
    bus.mode      = 2'b00;
    bus.delay     = 8'd3;
    bus.min_width = 8'd4;
    bus.clr_ovr   = '0;

    #1 reset = 1'b0;
    #2;
    check("rst_sig_out", 32'(bus.sig_out), 32'd0);
    check("rst_busy",    32'(bus.busy),    32'd0);
    check("rst_ovr",     32'(bus.ovr),     32'd0);
    while (cyc != 3) @(negedge clk);
    reset = 1'b1;

    // Rise on ch0 captured at edge 10, delay 3: strobe after edge 14, busy for 3 cycles.
    while (cyc != 9) @(negedge clk);
    bus.sig_in[0] = 1'b1;
    expect_strobe(0, 3);
    for (int t = 10; t <= 14 + SL; t++) begin
      step(1);
      check("t1_busy0", 32'(bus.busy[0]), 32'((t >= 11 + SL) && (t <= 13 + SL)));
    end
    check("t1_ovr", 32'(bus.ovr), 32'd0);
    bus.sig_in[0] = 1'b0;
    step(3);

    // Both edges, zero delay: 2-cycle pulse gives two strobes 2 cycles apart.
    bus.mode  = 2'b10;
    bus.delay = 8'd0;
    step(2);
    bus.sig_in[1] = 1'b1;
    expect_strobe(1, 0);
    step(2);
    bus.sig_in[1] = 1'b0;
    expect_strobe(1, 0);
    step(6);

    // Qualified high pulse, min_width 4.
    bus.mode = 2'b11;
    step(2);
    bus.sig_in[2] = 1'b1;
    step(3);
    bus.sig_in[2] = 1'b0;
    step(6);
    bus.sig_in[2] = 1'b1;
    step(4);
    bus.sig_in[2] = 1'b0;
    expect_strobe(2, 0);
    step(6);
    bus.ch_en[2]  = 1'b0;
    bus.sig_in[2] = 1'b1;
    step(4);
    bus.sig_in[2] = 1'b0;
    step(6);
    bus.ch_en[2]  = 1'b1;
    bus.sig_in[2] = 1'b1;
    step(300);
    bus.sig_in[2] = 1'b0;
    expect_strobe(2, 0);
    step(6);
    // A wrapping counter would present 44 here and miss the 255 threshold.
    bus.min_width = 8'd255;
    bus.sig_in[2] = 1'b1;
    step(300);
    bus.sig_in[2] = 1'b0;
    expect_strobe(2, 0);
    step(6);
    bus.min_width = 8'd4;

    // Overrun on ch3 with delay 5.
    bus.mode  = 2'b00;
    bus.delay = 8'd5;
    step(2);
    bus.sig_in[3] = 1'b1;
    expect_strobe(3, 5);
    step(1);
    bus.sig_in[3] = 1'b0;
    step(1);
    bus.sig_in[3] = 1'b1;
    step(2 + SL);
    check("ovr_set", 32'(bus.ovr[3]), 32'd1);
    check("ovr_busy", 32'(bus.busy[3]), 32'd1);
    bus.sig_in[3] = 1'b0;
    step(5);
    bus.clr_ovr[3] = 1'b1;
    step(1);
    bus.clr_ovr[3] = 1'b0;
    check("ovr_clr_alone_1", 32'(bus.ovr[3]), 32'd0);

    bus.sig_in[3] = 1'b1;
    expect_strobe(3, 5);
    step(1);
    bus.sig_in[3] = 1'b0;
    step(1);
    bus.sig_in[3] = 1'b1;
    step(1 + SL);
    bus.clr_ovr[3] = 1'b1;
    step(1);
    bus.clr_ovr[3] = 1'b0;
    check("ovr_set_beats_clr", 32'(bus.ovr[3]), 32'd1);
    bus.sig_in[3] = 1'b0;
    step(5);
    bus.clr_ovr[3] = 1'b1;
    step(1);
    bus.clr_ovr[3] = 1'b0;
    check("ovr_clr_alone_2", 32'(bus.ovr[3]), 32'd0);
    step(2);

    // Second rise evaluated exactly in the cnt==1 cycle is accepted.
    bus.sig_in[3] = 1'b1;
    expect_strobe(3, 5);
    step(1);
    bus.sig_in[3] = 1'b0;
    step(4);
    bus.sig_in[3] = 1'b1;
    expect_strobe(3, 5);
    step(2 + SL);
    check("last_cycle_reload_busy", 32'(bus.busy[3]), 32'd1);
    step(6);
    check("last_cycle_no_ovr", 32'(bus.ovr[3]), 32'd0);
    bus.sig_in[3] = 1'b0;
    step(3);

    // All channels rise together, delay 2.
    bus.delay = 8'd2;
    step(2);
    bus.sig_in = '1;
    for (int c = 0; c < NUM_CH; c++) expect_strobe(c, 2);
    step(2);
    check("all_busy", 32'(bus.busy), 32'hF);
    bus.sig_in = '0;
    step(6);

    // Reset while ch0 waits with cnt==2 and an overrun already flagged.
    bus.delay = 8'd4;
    step(2);
    bus.sig_in[0] = 1'b1;
    step(1);
    bus.sig_in[0] = 1'b0;
    step(1);
    bus.sig_in[0] = 1'b1;
    step(2 + SL);
    check("pre_rst_busy", 32'(bus.busy[0]), 32'd1);
    check("pre_rst_ovr", 32'(bus.ovr[0]), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy",    32'(bus.busy),    32'd0);
    check("mid_rst_sig_out", 32'(bus.sig_out), 32'd0);
    check("mid_rst_ovr",     32'(bus.ovr),     32'd0);
    bus.sig_in = '0;
    step(2);
    reset = 1'b1;
    step(12);
    check("post_rst_busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) step(1);
    while (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL pending_strobe_ch%0d: got none expected 1 at cycle %0d",
               exp_q[0].ch, exp_q[0].at);
      exp_q.delete(0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
